// File: rtl/reg_file_initiator.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_initiator
// Purpose  : Command-driven access sequencer for an 8x16 register file.
//            Accepts single/burst FILL, RAMP and READ commands over a
//            valid/ready handshake, drives the file's Address/WrData/WrEn/RdEn
//            port one beat per cycle and returns read data as a tagged
//            response stream. WrEn and RdEn are never asserted together.
// Ports    : CLK, RST (async, active-low)
//            cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_len/cmd_data : command in
//            Address/WrData/WrEn/RdEn/RdData : register file port
//            rsp_valid/rsp_addr/rsp_data     : read response (no backpressure)
//            done (1-cycle completion pulse), busy (state != IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_initiator #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_data,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] WrData,
    output logic          WrEn,
    output logic          RdEn,
    input  logic [DW-1:0] RdData,
    output logic          rsp_valid,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          done,
    output logic          busy
);

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_RAMP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [1:0]    op_lat, op_nxt;
    logic [AW-1:0] len_lat, len_nxt;
    logic [AW-1:0] addr_lat, addr_nxt;
    logic [DW-1:0] data_lat, data_nxt;
    logic [AW-1:0] address_nxt;
    logic [DW-1:0] wrdata_nxt;
    logic          wren_nxt, rden_nxt, done_nxt;
    logic [AW-1:0] beat_nxt;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // The file registers its read data, so it lines up with rsp_valid.
    assign rsp_data  = RdData;

    // Index of the beat to drive next; wraps in AW bits so bursts wrap the file.
    assign beat_nxt  = cnt + 1'b1;

    // File-port outputs are registered: the edge that accepts a command (or
    // advances the counter) loads the values for the beat of the next cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_nxt      = op_lat;
        len_nxt     = len_lat;
        addr_nxt    = addr_lat;
        data_nxt    = data_lat;
        address_nxt = Address;
        wrdata_nxt  = WrData;
        wren_nxt    = 1'b0;
        rden_nxt    = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt   = cmd_op;
                    len_nxt  = cmd_len;
                    addr_nxt = cmd_addr;
                    data_nxt = cmd_data;
                    cnt_nxt  = '0;
                    case (cmd_op)
                        OP_FILL, OP_RAMP: begin
                            state_nxt   = WR;
                            wren_nxt    = 1'b1;
                            address_nxt = cmd_addr;
                            wrdata_nxt  = cmd_data;
                        end
                        OP_READ: begin
                            state_nxt   = RD;
                            rden_nxt    = 1'b1;
                            address_nxt = cmd_addr;
                        end
                        default: begin
                            // Reserved op: no file access, just complete.
                            done_nxt = 1'b1;
                        end
                    endcase
                end
            end
            WR, RD: begin
                if (cnt == len_lat) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt     = beat_nxt;
                    address_nxt = addr_lat + beat_nxt;
                    if (state == WR) begin
                        wren_nxt   = 1'b1;
                        wrdata_nxt = (op_lat == OP_RAMP) ? data_lat + DW'(beat_nxt)
                                                         : data_lat;
                    end else begin
                        rden_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            op_lat    <= '0;
            len_lat   <= '0;
            addr_lat  <= '0;
            data_lat  <= '0;
            Address   <= '0;
            WrData    <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_lat    <= op_nxt;
            len_lat   <= len_nxt;
            addr_lat  <= addr_nxt;
            data_lat  <= data_nxt;
            Address   <= address_nxt;
            WrData    <= wrdata_nxt;
            WrEn      <= wren_nxt;
            RdEn      <= rden_nxt;
            done      <= done_nxt;
            // One-stage response pipeline, independent of the FSM.
            rsp_valid <= RdEn;
            rsp_addr  <= Address;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_initiator
// Purpose  : Self-checking bench for reg_file_initiator. Contains a simple
//            8x16 register file (registered read, cleared by RST) and a
//            reference memory image updated from the command semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_initiator;

    localparam int DW = 16;
    localparam int AW = 3;

    localparam logic [1:0] FILL = 2'b00;
    localparam logic [1:0] READ = 2'b01;
    localparam logic [1:0] RAMP = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    logic          CLK;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic          WrEn;
    logic          RdEn;
    logic [DW-1:0] RdData;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          done;
    logic          busy;

    int tests = 0;
    int fails = 0;

    // Reference image of the register file and the last value put on WrData.
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] last_wd;

    reg_file_initiator #(.DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .Address   (Address),
        .WrData    (WrData),
        .WrEn      (WrEn),
        .RdEn      (RdEn),
        .RdData    (RdData),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .done      (done),
        .busy      (busy)
    );

    // Register file: registered read port, shares the async reset.
    logic [DW-1:0] regfile [8];
    logic [DW-1:0] rd_q;
    assign RdData = rd_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < 8; k++) regfile[k] <= '0;
            rd_q <= '0;
        end else begin
            if (WrEn) regfile[Address] <= WrData;
            if (RdEn) rd_q <= regfile[Address];
        end
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // WrEn and RdEn must never be high together.
    always @(negedge CLK) begin
        tests++;
        assert (!(WrEn && RdEn)) else begin
            fails++;
            $error("FAIL excl WrEn=%0b RdEn=%0b expected not both 1", WrEn, RdEn);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_clear();
        for (int k = 0; k < 8; k++) ref_mem[k] = '0;
        last_wd = '0;
    endtask

    task automatic idle_check();
        @(negedge CLK);
        chk("idle_wren", WrEn, 0);
        chk("idle_rden", RdEn, 0);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rspv", rsp_valid, 0);
    endtask

    // Issue one command at a negedge with the DUT idle; check every beat and
    // the completion cycle. Returns at the negedge of the done cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a,
                           input logic [2:0] len, input logic [15:0] d,
                           input bit poke);
        logic [2:0]  ad;
        logic [2:0]  pa;
        logic [15:0] wd;
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_data  = d;
        @(negedge CLK);
        if (poke) begin
            // Garbage commands while busy must be ignored.
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom);
            cmd_addr  = 3'($urandom);
            cmd_len   = 3'($urandom);
            cmd_data  = 16'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        if (op == RSVD) begin
            chk("rsvd_done", done, 1);
            chk("rsvd_wren", WrEn, 0);
            chk("rsvd_rden", RdEn, 0);
            chk("rsvd_busy", busy, 0);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                ad = a + i[2:0];
                chk("beat_busy", busy, 1);
                chk("beat_done", done, 0);
                chk("beat_addr", Address, ad);
                if (op == READ) begin
                    chk("rd_rden", RdEn, 1);
                    chk("rd_wren", WrEn, 0);
                    chk("rd_wdata_hold", WrData, last_wd);
                    if (i > 0) begin
                        pa = ad - 3'd1;
                        chk("rsp_valid", rsp_valid, 1);
                        chk("rsp_addr", rsp_addr, pa);
                        chk("rsp_data", rsp_data, ref_mem[pa]);
                    end else begin
                        chk("rsp_valid0", rsp_valid, 0);
                    end
                end else begin
                    wd = (op == FILL) ? d : d + 16'(i);
                    chk("wr_wren", WrEn, 1);
                    chk("wr_rden", RdEn, 0);
                    chk("wr_data", WrData, wd);
                    chk("wr_rspv", rsp_valid, 0);
                    ref_mem[ad] = wd;
                    last_wd     = wd;
                end
                @(negedge CLK);
            end
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 0);
            chk("fin_wren", WrEn, 0);
            chk("fin_rden", RdEn, 0);
            chk("fin_rspv", rsp_valid, (op == READ) ? 1 : 0);
            if (op == READ) begin
                pa = a + len;
                chk("fin_rsp_addr", rsp_addr, pa);
                chk("fin_rsp_data", rsp_data, ref_mem[pa]);
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        ref_clear();
        // Reset held for 3 cycles with a command presented.
        RST       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = READ;
        cmd_addr  = 3'd0;
        cmd_len   = 3'd0;
        cmd_data  = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("rst_wren", WrEn, 0);
            chk("rst_rden", RdEn, 0);
            chk("rst_addr", Address, 0);
            chk("rst_wdata", WrData, 0);
            chk("rst_rspv", rsp_valid, 0);
            chk("rst_rspa", rsp_addr, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cmd_ready, 1);
        end
        RST = 1'b1;
        // Command still valid: accepted on the first edge after release.
        @(negedge CLK);
        chk("post_rst_rden", RdEn, 1);
        chk("post_rst_busy", busy, 1);
        chk("post_rst_addr", Address, 0);
        cmd_valid = 1'b0;
        @(negedge CLK);
        chk("post_rst_done", done, 1);
        chk("post_rst_rspv", rsp_valid, 1);
        chk("post_rst_rspd", rsp_data, 0);
        idle_check();

        // Full FILL then full READ, back to back.
        run_cmd(FILL, 3'd0, 3'd7, 16'hA5A5, 1'b0);
        run_cmd(READ, 3'd0, 3'd7, 16'h0000, 1'b0);
        idle_check();

        // RAMP across the wrap and across the 16-bit data rollover.
        run_cmd(RAMP, 3'd6, 3'd3, 16'hFFFE, 1'b0);
        run_cmd(READ, 3'd6, 3'd3, 16'h0000, 1'b0);
        chk("ramp_ref0", ref_mem[0], 16'h0000);
        chk("ramp_ref1", ref_mem[1], 16'h0001);

        // Single write, then read of the same address in the done cycle.
        run_cmd(FILL, 3'd3, 3'd0, 16'h5A17, 1'b0);
        run_cmd(READ, 3'd3, 3'd0, 16'h0000, 1'b0);
        idle_check();

        // Reserved op and commands presented while busy.
        run_cmd(RSVD, 3'd2, 3'd4, 16'hDEAD, 1'b0);
        idle_check();
        run_cmd(FILL, 3'd5, 3'd2, 16'h0F0F, 1'b1);
        idle_check();
        run_cmd(READ, 3'd4, 3'd4, 16'h0000, 1'b1);
        idle_check();

        // Reset in the middle of a READ burst.
        cmd_valid = 1'b1;
        cmd_op    = READ;
        cmd_addr  = 3'd4;
        cmd_len   = 3'd5;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_rden", RdEn, 1);
        chk("mid_rspv", rsp_valid, 1);
        RST = 1'b0;
        #1;
        chk("mid_rst_rspv", rsp_valid, 0);
        chk("mid_rst_rden", RdEn, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_addr", Address, 0);
        chk("mid_rst_done", done, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk("mid_rst_hold_done", done, 0);
            chk("mid_rst_hold_rden", RdEn, 0);
        end
        RST = 1'b1;
        ref_clear();
        @(negedge CLK);
        chk("post_mid_done", done, 0);
        run_cmd(READ, 3'd4, 3'd5, 16'h0000, 1'b0);
        idle_check();

        // Randomized command stream against the reference image.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  rop;
            logic [2:0]  ra;
            logic [2:0]  rl;
            logic [15:0] rd;
            bit          rp;
            rop = 2'($urandom_range(0, 3));
            ra  = 3'($urandom);
            rl  = 3'($urandom);
            rd  = 16'($urandom);
            rp  = 1'($urandom);
            run_cmd(rop, ra, rl, rd, rp);
            if ($urandom_range(0, 2) == 0) idle_check();
        end
        run_cmd(READ, 3'd0, 3'd7, 16'h0000, 1'b0);
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
